// File: rtl/fir_cmplx_dec.sv
//------------------------------------------------------------------------------
// fir_cmplx_dec : complex decimating FIR, LANES parallel complex MACs per cycle
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module fir_cmplx_dec #(
    parameter int DATA_WIDTH = 32,
    parameter int QUANT_BITS = 10,
    parameter int ACC_WIDTH  = 48,
    parameter int NUM_TAPS   = 20,
    parameter int LANES      = 1,
    parameter int DECIMATION = 1,
    parameter int SATURATE   = 0,
    parameter logic [0:NUM_TAPS-1][DATA_WIDTH-1:0] COEFF_REAL = '0,
    parameter logic [0:NUM_TAPS-1][DATA_WIDTH-1:0] COEFF_IMAG = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] xreal_in_dout,
    input  logic                  xreal_in_empty,
    output logic                  xreal_in_rd_en,
    input  logic [DATA_WIDTH-1:0] ximag_in_dout,
    input  logic                  ximag_in_empty,
    output logic                  ximag_in_rd_en,
    output logic [DATA_WIDTH-1:0] yreal_out_din,
    input  logic                  yreal_out_full,
    output logic                  yreal_out_wr_en,
    output logic [DATA_WIDTH-1:0] yimag_out_din,
    input  logic                  yimag_out_full,
    output logic                  yimag_out_wr_en,
    output logic                  busy
);

    localparam int c_groups = NUM_TAPS / LANES;
    localparam int c_grp_w  = (c_groups > 1) ? $clog2(c_groups) : 1;
    localparam int c_dec_w  = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam int c_tap_w  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int c_pw     = 2 * DATA_WIDTH;
    localparam int c_sw     = c_pw + 1;

    localparam logic [c_grp_w-1:0] c_grp_last = c_grp_w'(c_groups - 1);
    localparam logic [c_dec_w-1:0] c_dec_last = c_dec_w'(DECIMATION - 1);
    localparam logic signed [c_sw-1:0] c_rnd  = (c_sw'(1) << QUANT_BITS) - c_sw'(1);
    localparam logic signed [ACC_WIDTH-1:0] c_sat_max =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_sat_min =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    if (NUM_TAPS % LANES != 0) begin : g_lanes_check
        $error("fir_cmplx_dec: NUM_TAPS must be a multiple of LANES");
    end

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                       r_state;
    logic [DATA_WIDTH-1:0]        r_xr [NUM_TAPS];
    logic [DATA_WIDTH-1:0]        r_xi [NUM_TAPS];
    logic [c_dec_w-1:0]           r_dec_cnt;
    logic [c_grp_w-1:0]           r_grp;
    logic signed [ACC_WIDTH-1:0]  r_acc_re;
    logic signed [ACC_WIDTH-1:0]  r_acc_im;

    logic                         w_rd;
    logic                         w_wr;
    logic signed [ACC_WIDTH-1:0]  w_lane_re [LANES];
    logic signed [ACC_WIDTH-1:0]  w_lane_im [LANES];
    logic signed [ACC_WIDTH-1:0]  w_sum_re;
    logic signed [ACC_WIDTH-1:0]  w_sum_im;

    function automatic logic signed [c_pw-1:0] mul(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return c_pw'(a) * c_pw'(b);
    endfunction

    // Divide by 2^QUANT_BITS rounding toward zero, then fit to accumulator width.
    function automatic logic signed [ACC_WIDTH-1:0] dequant(input logic signed [c_sw-1:0] v);
        logic signed [c_sw-1:0] t;
        t = v[c_sw-1] ? (v + c_rnd) : v;
        t = t >>> QUANT_BITS;
        return ACC_WIDTH'(t);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] reduce(input logic signed [ACC_WIDTH-1:0] a);
        if (SATURATE != 0 && a > c_sat_max) return c_sat_max[DATA_WIDTH-1:0];
        if (SATURATE != 0 && a < c_sat_min) return c_sat_min[DATA_WIDTH-1:0];
        return a[DATA_WIDTH-1:0];
    endfunction

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [c_tap_w-1:0]     w_idx;
        logic signed [c_pw-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;

        assign w_idx        = c_tap_w'(r_grp * LANES + l);
        assign w_p_rr       = mul(r_xr[w_idx], COEFF_REAL[w_idx]);
        assign w_p_ii       = mul(r_xi[w_idx], COEFF_IMAG[w_idx]);
        assign w_p_ri       = mul(r_xr[w_idx], COEFF_IMAG[w_idx]);
        assign w_p_ir       = mul(r_xi[w_idx], COEFF_REAL[w_idx]);
        assign w_lane_re[l] = dequant(c_sw'(w_p_rr) - c_sw'(w_p_ii));
        assign w_lane_im[l] = dequant(c_sw'(w_p_ri) + c_sw'(w_p_ir));
    end

    always_comb begin
        w_sum_re = '0;
        w_sum_im = '0;
        for (int l = 0; l < LANES; l++) begin
            w_sum_re = w_sum_re + w_lane_re[l];
            w_sum_im = w_sum_im + w_lane_im[l];
        end
    end

    // The input pair and output pair each move together or not at all.
    assign w_rd = (r_state == S_LOAD) && !xreal_in_empty && !ximag_in_empty;
    assign w_wr = (r_state == S_WRITE) && !yreal_out_full && !yimag_out_full;

    assign xreal_in_rd_en  = w_rd;
    assign ximag_in_rd_en  = w_rd;
    assign yreal_out_wr_en = w_wr;
    assign yimag_out_wr_en = w_wr;
    assign yreal_out_din   = w_wr ? reduce(r_acc_re) : '0;
    assign yimag_out_din   = w_wr ? reduce(r_acc_im) : '0;
    assign busy            = (r_state != S_LOAD);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_LOAD;
            r_dec_cnt <= '0;
            r_grp     <= '0;
            r_acc_re  <= '0;
            r_acc_im  <= '0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_xr[k] <= '0;
                r_xi[k] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_rd) begin
                        r_xr[0] <= xreal_in_dout;
                        r_xi[0] <= ximag_in_dout;
                        for (int k = 1; k < NUM_TAPS; k++) begin
                            r_xr[k] <= r_xr[k-1];
                            r_xi[k] <= r_xi[k-1];
                        end
                        if (r_dec_cnt == c_dec_last) begin
                            r_dec_cnt <= '0;
                            r_grp     <= '0;
                            r_acc_re  <= '0;
                            r_acc_im  <= '0;
                            r_state   <= S_MAC;
                        end else begin
                            r_dec_cnt <= r_dec_cnt + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    r_acc_re <= r_acc_re + w_sum_re;
                    r_acc_im <= r_acc_im + w_sum_im;
                    if (r_grp == c_grp_last) begin
                        r_grp   <= '0;
                        r_state <= S_WRITE;
                    end else begin
                        r_grp <= r_grp + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (w_wr) r_state <= S_LOAD;
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fir_cmplx_dec.sv
//------------------------------------------------------------------------------
// tb_fir_cmplx_dec : directed self-checking bench, five filter configurations
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fir_cmplx_dec;

    logic clk;
    logic rst;

    // Index 0: passthrough, 1: complex coeff, 2: decimate-by-3, 3: 16b saturating, 4: 16b wrapping
    logic [4:0][31:0] xr, xi;
    logic [4:0]       er, ei, fr, fi;
    wire  [4:0][31:0] yr, yi;
    wire  [4:0]       rd_r, rd_i, wr_r, wr_i, bsy;

    int n_cmp = 0;
    int n_err = 0;
    int rd_cnt [5] = '{default: 0};
    int wr_cnt [5] = '{default: 0};

    assign yr[3][31:16] = '0;
    assign yi[3][31:16] = '0;
    assign yr[4][31:16] = '0;
    assign yi[4][31:16] = '0;

    fir_cmplx_dec #(
        .DATA_WIDTH(32), .QUANT_BITS(10), .ACC_WIDTH(48), .NUM_TAPS(4), .LANES(2),
        .DECIMATION(1), .SATURATE(0),
        .COEFF_REAL({32'd1024, 32'd0, 32'd0, 32'd0}), .COEFF_IMAG(128'd0)
    ) u_a (
        .clock(clk), .reset(rst),
        .xreal_in_dout(xr[0]), .xreal_in_empty(er[0]), .xreal_in_rd_en(rd_r[0]),
        .ximag_in_dout(xi[0]), .ximag_in_empty(ei[0]), .ximag_in_rd_en(rd_i[0]),
        .yreal_out_din(yr[0]), .yreal_out_full(fr[0]), .yreal_out_wr_en(wr_r[0]),
        .yimag_out_din(yi[0]), .yimag_out_full(fi[0]), .yimag_out_wr_en(wr_i[0]),
        .busy(bsy[0])
    );

    fir_cmplx_dec #(
        .DATA_WIDTH(32), .QUANT_BITS(10), .ACC_WIDTH(48), .NUM_TAPS(2), .LANES(1),
        .DECIMATION(1), .SATURATE(0),
        .COEFF_REAL({32'd512, 32'd0}), .COEFF_IMAG({32'd1024, 32'd0})
    ) u_b (
        .clock(clk), .reset(rst),
        .xreal_in_dout(xr[1]), .xreal_in_empty(er[1]), .xreal_in_rd_en(rd_r[1]),
        .ximag_in_dout(xi[1]), .ximag_in_empty(ei[1]), .ximag_in_rd_en(rd_i[1]),
        .yreal_out_din(yr[1]), .yreal_out_full(fr[1]), .yreal_out_wr_en(wr_r[1]),
        .yimag_out_din(yi[1]), .yimag_out_full(fi[1]), .yimag_out_wr_en(wr_i[1]),
        .busy(bsy[1])
    );

    fir_cmplx_dec #(
        .DATA_WIDTH(32), .QUANT_BITS(10), .ACC_WIDTH(48), .NUM_TAPS(4), .LANES(2),
        .DECIMATION(3), .SATURATE(0),
        .COEFF_REAL({4{32'd1024}}), .COEFF_IMAG(128'd0)
    ) u_c (
        .clock(clk), .reset(rst),
        .xreal_in_dout(xr[2]), .xreal_in_empty(er[2]), .xreal_in_rd_en(rd_r[2]),
        .ximag_in_dout(xi[2]), .ximag_in_empty(ei[2]), .ximag_in_rd_en(rd_i[2]),
        .yreal_out_din(yr[2]), .yreal_out_full(fr[2]), .yreal_out_wr_en(wr_r[2]),
        .yimag_out_din(yi[2]), .yimag_out_full(fi[2]), .yimag_out_wr_en(wr_i[2]),
        .busy(bsy[2])
    );

    fir_cmplx_dec #(
        .DATA_WIDTH(16), .QUANT_BITS(10), .ACC_WIDTH(48), .NUM_TAPS(4), .LANES(4),
        .DECIMATION(1), .SATURATE(1),
        .COEFF_REAL({4{16'd32767}}), .COEFF_IMAG(64'd0)
    ) u_d (
        .clock(clk), .reset(rst),
        .xreal_in_dout(xr[3][15:0]), .xreal_in_empty(er[3]), .xreal_in_rd_en(rd_r[3]),
        .ximag_in_dout(xi[3][15:0]), .ximag_in_empty(ei[3]), .ximag_in_rd_en(rd_i[3]),
        .yreal_out_din(yr[3][15:0]), .yreal_out_full(fr[3]), .yreal_out_wr_en(wr_r[3]),
        .yimag_out_din(yi[3][15:0]), .yimag_out_full(fi[3]), .yimag_out_wr_en(wr_i[3]),
        .busy(bsy[3])
    );

    fir_cmplx_dec #(
        .DATA_WIDTH(16), .QUANT_BITS(10), .ACC_WIDTH(48), .NUM_TAPS(4), .LANES(4),
        .DECIMATION(1), .SATURATE(0),
        .COEFF_REAL({4{16'd32767}}), .COEFF_IMAG(64'd0)
    ) u_e (
        .clock(clk), .reset(rst),
        .xreal_in_dout(xr[4][15:0]), .xreal_in_empty(er[4]), .xreal_in_rd_en(rd_r[4]),
        .ximag_in_dout(xi[4][15:0]), .ximag_in_empty(ei[4]), .ximag_in_rd_en(rd_i[4]),
        .yreal_out_din(yr[4][15:0]), .yreal_out_full(fr[4]), .yreal_out_wr_en(wr_r[4]),
        .yimag_out_din(yi[4][15:0]), .yimag_out_full(fi[4]), .yimag_out_wr_en(wr_i[4]),
        .busy(bsy[4])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (rd_r[i]) rd_cnt[i] <= rd_cnt[i] + 1;
            if (wr_r[i]) wr_cnt[i] <= wr_cnt[i] + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Present one input pair and hold it until both pops are seen (bounded).
    task automatic push(input int id, input logic [31:0] r, input logic [31:0] i);
        bit got;
        got = 1'b0;
        xr[id] = r;
        xi[id] = i;
        er[id] = 1'b0;
        ei[id] = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            #1;
            if (rd_r[id] && rd_i[id]) got = 1'b1;
            @(negedge clk);
        end
        er[id] = 1'b1;
        ei[id] = 1'b1;
        if (!got) check_val("push_timeout", 32'd0, 32'd1);
    endtask

    // Wait (bounded) for a write and compare it; lat >= 0 also checks cycles since the read.
    task automatic expect_out(input int id, input logic [31:0] exp_r, input logic [31:0] exp_i,
                              input int lat);
        bit got;
        int waited;
        got = 1'b0;
        waited = 0;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (wr_r[id]) begin
                got = 1'b1;
                waited = n;
                break;
            end
            @(negedge clk);
        end
        if (got) begin
            check_val("wr_pair", {31'd0, wr_i[id]}, 32'd1);
            check_val("out_real", yr[id], exp_r);
            check_val("out_imag", yi[id], exp_i);
            if (lat >= 0) check_val("latency", waited + 1, lat);
            @(negedge clk);
        end else begin
            check_val("wr_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        int c0;
        int bad;
        rst = 1'b1;
        xr = '0;
        xi = '0;
        er = '1;
        ei = '1;
        fr = '0;
        fi = '0;
        repeat (3) @(negedge clk);
        check_val("rst_rd_en", {31'd0, rd_r[0] | rd_i[0]}, 32'd0);
        check_val("rst_wr_en", {31'd0, wr_r[0] | wr_i[0]}, 32'd0);
        check_val("rst_busy",  {31'd0, bsy[0]}, 32'd0);
        check_val("rst_din",   yr[0] | yi[0], 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Passthrough with 3-cycle read-to-write latency
        push(0, 32'd3072, -32'sd2048);
        expect_out(0, 32'd3072, -32'sd2048, 3);
        push(0, 32'd5, 32'd7);
        expect_out(0, 32'd5, 32'd7, 3);

        // Imaginary FIFO empty: nothing may be read
        xr[0] = 32'd9;
        er[0] = 1'b0;
        ei[0] = 1'b1;
        c0 = rd_cnt[0];
        repeat (6) @(negedge clk);
        check_val("no_split_read", rd_cnt[0] - c0, 32'd0);
        push(0, 32'd9, 32'd4);
        expect_out(0, 32'd9, 32'd4, 3);

        // Output stall on imaginary full
        fi[0] = 1'b1;
        push(0, 32'd11, 32'd22);
        repeat (2) @(negedge clk);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (wr_r[0] || wr_i[0] || yr[0] != 0 || yi[0] != 0) bad++;
            @(negedge clk);
        end
        check_val("stall_quiet", bad, 32'd0);
        check_val("stall_busy", {31'd0, bsy[0]}, 32'd1);
        c0 = wr_cnt[0];
        fi[0] = 1'b0;
        expect_out(0, 32'd11, 32'd22, -1);
        repeat (3) @(negedge clk);
        check_val("stall_one_write", wr_cnt[0] - c0, 32'd1);

        // Complex coefficient 0.5 + j, truncation toward zero
        push(1, 32'd3072, 32'd5120);
        expect_out(1, -32'sd3584, 32'd5632, -1);
        push(1, -32'sd1, 32'd0);
        expect_out(1, 32'd0, -32'sd1, -1);
        push(1, -32'sd3, 32'd0);
        expect_out(1, -32'sd1, -32'sd3, -1);
        push(1, 32'd3, 32'd0);
        expect_out(1, 32'd1, 32'd3, -1);
        push(1, 32'd0, 32'd1);
        expect_out(1, -32'sd1, 32'd0, -1);

        // Decimate by 3 over a 4-tap all-ones filter
        push(2, 32'd1, 32'd0);
        push(2, 32'd2, 32'd0);
        push(2, 32'd3, 32'd0);
        expect_out(2, 32'd6, 32'd0, -1);
        push(2, 32'd4, 32'd0);
        push(2, 32'd5, 32'd0);
        push(2, 32'd6, 32'd0);
        expect_out(2, 32'd18, 32'd0, -1);
        repeat (2) @(negedge clk);
        check_val("dec_write_count", wr_cnt[2], 32'd2);

        // Reset on the second MAC cycle: no write, history cleared
        push(2, 32'd10, 32'd0);
        push(2, 32'd20, 32'd0);
        push(2, 32'd30, 32'd0);
        c0 = wr_cnt[2];
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_val("rst_no_write", wr_cnt[2] - c0, 32'd0);
        check_val("rst_idle", {31'd0, bsy[2]}, 32'd0);
        push(2, 32'd1, 32'd0);
        push(2, 32'd2, 32'd0);
        push(2, 32'd3, 32'd0);
        expect_out(2, 32'd6, 32'd0, -1);

        // 16-bit saturating instance
        push(3, 32'h7FFF, 32'd0);
        expect_out(3, 32'h7FFF, 32'd0, -1);
        push(3, 32'h8000, 32'd0);
        expect_out(3, 32'hFFE0, 32'd0, -1);
        push(3, 32'h8000, 32'd0);
        expect_out(3, 32'h8000, 32'd0, -1);

        // 16-bit wrapping instance
        push(4, 32'h7FFF, 32'd0);
        expect_out(4, 32'hFFC0, 32'd0, -1);
        push(4, 32'h8000, 32'd0);
        expect_out(4, 32'hFFE0, 32'd0, -1);
        push(4, 32'h8000, 32'd0);
        expect_out(4, 32'h0000, 32'd0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

`default_nettype wire
